instr_realigner: RTL and testbench

- Sits between the instruction fetch interface and the compressed decoder.
- Consumes word-aligned 32-bit fetch words and splits each into individual 16-bit (RVC) or 32-bit instructions.
- Reassembles 32-bit instructions that straddle two fetch words.
- Presents one instruction per cycle, with its PC, from a registered output stage with a valid/ready handshake.

---
 rtl/ariane_pkg.sv | 22 ++
 rtl/instr_realigner_out_reg.sv | 34 +++
 rtl/instr_realigner.sv | 177 +++++++++++++++++
 tb/tb_instr_realigner.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared front-end types for the instruction fetch path.
//   VLEN          : width of the pc field carried in fetch_entry_t
//   INSTR_HALF_W  : width of one instruction parcel (RVC halfword)
//   fetch_entry_t : one decoded-boundary instruction with pc and fault flag
//   is_rvc()      : true when a halfword starts a compressed instruction
package ariane_pkg;

  localparam int unsigned VLEN         = 64;
  localparam int unsigned INSTR_HALF_W = 16;

  typedef struct packed {
    logic [31:0]     instr;
    logic [VLEN-1:0] pc;
    logic            is_compressed;
    logic            ex;
  } fetch_entry_t;

  function automatic logic is_rvc(input logic [INSTR_HALF_W-1:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_realigner_out_reg.sv
// Single-entry valid/ready pipeline register for fetch_entry_t.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drops the held entry (valid clears next cycle)
//   in_valid/in_entry : entry offered this cycle
//   out_valid/out_entry/out_ready : registered entry and consumer handshake
// The register reloads whenever it is empty or its entry is being taken;
// if nothing is offered in such a cycle, valid simply drops.
module fetch_out_reg
  import ariane_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_entry <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_entry <= in_entry;
    end
  end

endmodule

// File: rtl/instr_realigner.sv
// Instruction realigner: splits word-aligned 32-bit fetch words into 16-bit
// (RVC) and 32-bit instructions, stitching 32-bit instructions that straddle
// two fetch words, and presents one instruction per cycle with its pc.
// Build option: REALIGN_RVC_EN enables compressed-instruction realignment.
// Without it every word is emitted whole, and a word that is not a clean
// aligned 32-bit instruction is flagged with ex_o.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   flush_i              : drop all buffered state (branch/exception/fence)
//   fetch_valid_i/_ready_o, fetch_rdata_i, fetch_addr_i, fetch_ex_i : fetch side
//   instr_valid_o/instr_ready_i, instr_o, pc_o, is_compressed_o, ex_o : decode side
// VLEN must not exceed ariane_pkg::VLEN (pc is carried in the shared entry type).
module instr_realigner
  import ariane_pkg::fetch_entry_t;
  import ariane_pkg::INSTR_HALF_W;
  import ariane_pkg::is_rvc;
#(
  parameter int unsigned VLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_rdata_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  input  logic            fetch_ex_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [VLEN-1:0] pc_o,
  output logic            is_compressed_o,
  output logic            ex_o
);

  logic            blocked;
  logic            advance;
  logic            produce;
  logic [31:0]     instr_d;
  logic [VLEN-1:0] pc_d;
  logic            is_compressed_d;
  logic            ex_d;
  fetch_entry_t    entry_d;
  fetch_entry_t    entry_q;

  // Only the blocked term couples instr_ready_i into fetch_ready_o.
  assign blocked = instr_valid_o && !instr_ready_i;
  assign advance = fetch_valid_i && !blocked && !flush_i && !rst_i;

`ifdef REALIGN_RVC_EN

  typedef enum logic [1:0] {ALIGNED, HI, STRADDLE} state_e;

  state_e                  state_q, state_d;
  logic [INSTR_HALF_W-1:0] leftover_q;
  logic [VLEN-1:0]         leftover_pc_q;
  logic                    latch_leftover;
  logic [INSTR_HALF_W-1:0] lo, hi;
  logic [VLEN-1:0]         lo_pc, hi_pc;
  logic                    in_hi;

  assign lo    = fetch_rdata_i[INSTR_HALF_W-1:0];
  assign hi    = fetch_rdata_i[31:INSTR_HALF_W];
  assign lo_pc = {fetch_addr_i[VLEN-1:2], 2'b00};
  assign hi_pc = {fetch_addr_i[VLEN-1:2], 2'b10};
  // A branch target on the hi half is handled exactly like the HI state.
  assign in_hi = (state_q == HI) || (state_q == ALIGNED && fetch_addr_i[1]);

  always_comb begin
    state_d        = state_q;
    latch_leftover = 1'b0;
    produce        = 1'b0;
    fetch_ready_o  = 1'b0;
    instr_d        = '0;
    pc_d           = lo_pc;
    ex_d           = 1'b0;
    if (advance) begin
      if (fetch_ex_i) begin
        produce       = 1'b1;
        ex_d          = 1'b1;
        fetch_ready_o = 1'b1;
        state_d       = ALIGNED;
        pc_d          = (state_q == STRADDLE) ? leftover_pc_q : (in_hi ? hi_pc : lo_pc);
      end else if (state_q == STRADDLE) begin
        // Upper parcel of the split instruction; this word's hi half is next.
        produce = 1'b1;
        instr_d = {lo, leftover_q};
        pc_d    = leftover_pc_q;
        state_d = HI;
      end else if (in_hi) begin
        fetch_ready_o = 1'b1;
        if (is_rvc(hi)) begin
          produce = 1'b1;
          instr_d = {{INSTR_HALF_W{1'b0}}, hi};
          pc_d    = hi_pc;
          state_d = ALIGNED;
        end else begin
          latch_leftover = 1'b1;
          state_d        = STRADDLE;
        end
      end else if (is_rvc(lo)) begin
        produce = 1'b1;
        instr_d = {{INSTR_HALF_W{1'b0}}, lo};
        state_d = HI;
      end else begin
        produce       = 1'b1;
        instr_d       = fetch_rdata_i;
        fetch_ready_o = 1'b1;
      end
    end
  end

  assign is_compressed_d = is_rvc(instr_d[INSTR_HALF_W-1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= ALIGNED;
    end else if (advance) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      leftover_q    <= '0;
      leftover_pc_q <= '0;
    end else if (latch_leftover) begin
      leftover_q    <= hi;
      leftover_pc_q <= hi_pc;
    end
  end

`else

  // Whole-word mode: anything that is not an aligned 32-bit instruction is
  // passed on as a fault so the decoder raises it.
  always_comb begin
    produce       = advance;
    fetch_ready_o = advance;
    pc_d          = fetch_addr_i;
    ex_d          = 1'b0;
    instr_d       = '0;
    if (advance) begin
      ex_d    = fetch_ex_i || fetch_addr_i[1] || is_rvc(fetch_rdata_i[INSTR_HALF_W-1:0]);
      instr_d = fetch_ex_i ? '0 : fetch_rdata_i;
    end
  end

  assign is_compressed_d = 1'b0;

`endif

  always_comb begin
    entry_d               = '0;
    entry_d.instr         = instr_d;
    entry_d.pc[VLEN-1:0]  = pc_d;
    entry_d.is_compressed = is_compressed_d;
    entry_d.ex            = ex_d;
  end

  fetch_out_reg u_out_reg (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .in_valid  (produce),
    .in_entry  (entry_d),
    .out_valid (instr_valid_o),
    .out_ready (instr_ready_i),
    .out_entry (entry_q)
  );

  assign instr_o         = entry_q.instr;
  assign pc_o            = entry_q.pc[VLEN-1:0];
  assign is_compressed_o = entry_q.is_compressed;
  assign ex_o            = entry_q.ex;

endmodule

// File: tb/tb_instr_realigner.sv
// Directed testbench for instr_realigner. Each scenario builds a table of
// per-cycle inputs with hand-computed fetch_ready_o and the entry expected
// in the output register after the clock edge. Expectations follow the
// REALIGN_RVC_EN build option.
module tb_instr_realigner;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, fetch_valid_i, fetch_ex_i, instr_ready_i;
  logic [31:0] fetch_rdata_i;
  logic [63:0] fetch_addr_i;
  logic        fetch_ready_o, instr_valid_o, is_compressed_o, ex_o;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic [98:0] obs;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_realigner #(.VLEN(64)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_rdata_i   (fetch_rdata_i),
    .fetch_addr_i    (fetch_addr_i),
    .fetch_ex_i      (fetch_ex_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .is_compressed_o (is_compressed_o),
    .ex_o            (ex_o)
  );

  assign obs = {instr_valid_o, instr_o, pc_o, is_compressed_o, ex_o};

  // control = {rst, fetch_valid, fetch_ex, flush, instr_ready}
  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] FETCH = 5'b01001;
  localparam logic [4:0] FAULT = 5'b01101;
  localparam logic [4:0] FLUSH = 5'b01011;
  localparam logic [4:0] FLSTL = 5'b01010;
  localparam logic [4:0] STALL = 5'b01000;
  localparam logic [4:0] RESET = 5'b11001;
  // expected output = {valid, is_compressed, ex}
  localparam logic [2:0] O_NONE = 3'b000;
  localparam logic [2:0] O_FULL = 3'b100;
  localparam logic [2:0] O_RVC  = 3'b110;
  localparam logic [2:0] O_EX   = 3'b101;
  localparam logic [2:0] O_EXC  = 3'b111;

  typedef struct packed {
    logic [4:0]  c;
    logic [31:0] d;
    logic [63:0] a;
    logic        rdy;
    logic [2:0]  o;
    logic [31:0] oi;
    logic [63:0] opc;
  } row_t;

  function automatic row_t mk(input logic [4:0] c, input logic [31:0] d, input logic [63:0] a,
                              input logic rdy, input logic [2:0] o, input logic [31:0] oi,
                              input logic [63:0] opc);
    row_t r;
    r.c = c; r.d = d; r.a = a; r.rdy = rdy; r.o = o; r.oi = oi; r.opc = opc;
    return r;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b1; fetch_ex_i = 1'b0;
    instr_ready_i = 1'b1; fetch_rdata_i = 32'h0000_0013; fetch_addr_i = 64'h100;
    @(posedge clk); #1;
    total++;
    if (fetch_ready_o !== 1'b0) $display("FAIL reset fetch_ready_o got %b want 0", fetch_ready_o);
    else passed++;
    total++;
    if (obs !== '0) $display("FAIL reset outputs got %h want 0", obs);
    else passed++;
    rst_i = 1'b0; fetch_valid_i = 1'b0;
  endtask

  task automatic test_aligned_word();
    row_t rows[$];
    logic [98:0] exp_v;
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h8000_0000, 1'b1, O_FULL, 32'h0000_0013, 64'h8000_0000));
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL aligned[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL aligned[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_rvc_pair();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0001_4501, 64'h1000, 1'b0, O_RVC, 32'h0000_4501, 64'h1000));
    rows.push_back(mk(FETCH, 32'h0001_4501, 64'h1000, 1'b1, O_RVC, 32'h0000_0001, 64'h1002));
`else
    rows.push_back(mk(FETCH, 32'h0001_4501, 64'h1000, 1'b1, O_EX, 32'h0001_4501, 64'h1000));
`endif
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL rvc_pair[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL rvc_pair[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_straddle();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h2000, 1'b0, O_RVC, 32'h0000_0001, 64'h2000));
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h2000, 1'b1, O_NONE, '0, '0));
    rows.push_back(mk(FETCH, 32'hABCD_0000, 64'h2004, 1'b0, O_FULL, 32'h0000_0013, 64'h2002));
    rows.push_back(mk(FETCH, 32'hABCD_0000, 64'h2004, 1'b1, O_RVC, 32'h0000_ABCD, 64'h2006));
`else
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h2000, 1'b1, O_EX, 32'h0013_0001, 64'h2000));
    rows.push_back(mk(FETCH, 32'hABCD_0000, 64'h2004, 1'b1, O_EX, 32'hABCD_0000, 64'h2004));
`endif
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL straddle[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL straddle[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0001_4501, 64'h4000, 1'b0, O_RVC, 32'h0000_4501, 64'h4000));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(STALL, 32'h0001_4501, 64'h4000, 1'b0, O_RVC, 32'h0000_4501, 64'h4000));
    rows.push_back(mk(FETCH, 32'h0001_4501, 64'h4000, 1'b1, O_RVC, 32'h0000_0001, 64'h4002));
`else
    rows.push_back(mk(FETCH, 32'h0001_4501, 64'h4000, 1'b1, O_EX, 32'h0001_4501, 64'h4000));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(STALL, 32'h0000_0013, 64'h4004, 1'b0, O_EX, 32'h0001_4501, 64'h4000));
`endif
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h4004, 1'b1, O_FULL, 32'h0000_0013, 64'h4004));
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL backpressure[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL backpressure[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0013_4501, 64'h2FFC, 1'b0, O_RVC, 32'h0000_4501, 64'h2FFC));
    rows.push_back(mk(FETCH, 32'h0013_4501, 64'h2FFC, 1'b1, O_NONE, '0, '0));
`else
    rows.push_back(mk(FETCH, 32'h0013_4501, 64'h2FFC, 1'b1, O_EX, 32'h0013_4501, 64'h2FFC));
`endif
    rows.push_back(mk(FLUSH, 32'h0000_0013, 64'h3000, 1'b0, O_NONE, '0, '0));
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h3000, 1'b1, O_FULL, 32'h0000_0013, 64'h3000));
    rows.push_back(mk(FLSTL, 32'h0000_0013, 64'h3004, 1'b0, O_NONE, '0, '0));
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h3004, 1'b1, O_FULL, 32'h0000_0013, 64'h3004));
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL flush[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL flush[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_fault();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h5000, 1'b0, O_RVC, 32'h0000_0001, 64'h5000));
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h5000, 1'b1, O_NONE, '0, '0));
    rows.push_back(mk(FAULT, 32'hDEAD_BEEF, 64'h5004, 1'b1, O_EXC, 32'h0, 64'h5002));
`else
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h5000, 1'b1, O_EX, 32'h0013_0001, 64'h5000));
    rows.push_back(mk(FAULT, 32'hDEAD_BEEF, 64'h5004, 1'b1, O_EX, 32'h0, 64'h5004));
`endif
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h5008, 1'b1, O_FULL, 32'h0000_0013, 64'h5008));
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL fault[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL fault[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_straddle();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h7000, 1'b0, O_RVC, 32'h0000_0001, 64'h7000));
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h7000, 1'b1, O_NONE, '0, '0));
`else
    rows.push_back(mk(FETCH, 32'h0013_0001, 64'h7000, 1'b1, O_EX, 32'h0013_0001, 64'h7000));
`endif
    rows.push_back(mk(RESET, 32'h0000_0013, 64'h7004, 1'b0, O_NONE, '0, '0));
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h7004, 1'b1, O_FULL, 32'h0000_0013, 64'h7004));
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL rst_straddle[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL rst_straddle[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_branch_target();
    row_t rows[$];
    logic [98:0] exp_v;
`ifdef REALIGN_RVC_EN
    rows.push_back(mk(FETCH, 32'h0001_0000, 64'h6002, 1'b1, O_RVC, 32'h0000_0001, 64'h6002));
    rows.push_back(mk(FETCH, 32'h0013_0000, 64'h6006, 1'b1, O_NONE, '0, '0));
    rows.push_back(mk(FETCH, 32'h4501_0000, 64'h6008, 1'b0, O_FULL, 32'h0000_0013, 64'h6006));
    rows.push_back(mk(FETCH, 32'h4501_0000, 64'h6008, 1'b1, O_RVC, 32'h0000_4501, 64'h600A));
`else
    rows.push_back(mk(FETCH, 32'h0001_0000, 64'h6002, 1'b1, O_EX, 32'h0001_0000, 64'h6002));
    rows.push_back(mk(FETCH, 32'h0000_0013, 64'h6008, 1'b1, O_FULL, 32'h0000_0013, 64'h6008));
`endif
    rows.push_back(mk(IDLE, '0, '0, 1'b0, O_NONE, '0, '0));
    foreach (rows[i]) begin
      {rst_i, fetch_valid_i, fetch_ex_i, flush_i, instr_ready_i} = rows[i].c;
      fetch_rdata_i = rows[i].d; fetch_addr_i = rows[i].a;
      #1;
      total++;
      if (fetch_ready_o !== rows[i].rdy)
        $display("FAIL branch[%0d] fetch_ready_o got %b want %b", i, fetch_ready_o, rows[i].rdy);
      else passed++;
      @(posedge clk); #1;
      exp_v = {rows[i].o[2], rows[i].oi, rows[i].opc, rows[i].o[1:0]};
      total++;
      if (rows[i].o[2] ? (obs !== exp_v) : (instr_valid_o !== 1'b0))
        $display("FAIL branch[%0d] out got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_ex_i = 1'b0;
    instr_ready_i = 1'b1; fetch_rdata_i = '0; fetch_addr_i = '0;
    test_reset();
    test_aligned_word();
    test_rvc_pair();
    test_straddle();
    test_backpressure();
    test_flush();
    test_fault();
    test_reset_mid_straddle();
    test_branch_target();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
